// File: rtl/multicycle_control_pkg.sv
// multicycle_control_pkg
// Shared encodings for the multicycle controller: FSM states, supported
// opcodes, ALU operation codes and datapath mux-select codes, plus a helper
// that classifies an opcode as supported.
package multicycle_control_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_RFN = 2'b10;  // R-type, ALU decodes funct
  localparam logic [1:0] ALU_IFN = 2'b11;  // I-type, ALU decodes funct

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JALR   = 2'b10;  // ALU result with bit0 cleared

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  function automatic logic op_supported(input logic [6:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) || (op == OP_STORE) ||
           (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR);
  endfunction

endpackage

// File: rtl/multicycle_control.sv
// multicycle_control
// Control FSM for a multicycle RISC-V style datapath:
// FETCH -> DECODE -> EXEC -> (MEM) -> (WB) -> FETCH, HALT on an unsupported opcode.
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   opcode[6:0]      opcode from the external instruction register
//   mem_ready        memory finishes the current access this cycle
//   mem_read/write   memory requests
//   ir_write, pc_write, pc_write_cond, pc_source[1:0]
//   alu_src_a[1:0], alu_src_b[1:0], alu_op[1:0]
//   reg_write, mem_to_reg[1:0]
//   illegal_inst     sticky: high while halted on an unsupported opcode
//   instret          retired-instruction count (only with INSTRET_CNT_EN)
// Optional feature macro: INSTRET_CNT_EN (retired-instruction counter).
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int INSTRET_W = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_source,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_write,
  output logic [1:0] mem_to_reg,
  output logic       illegal_inst
`ifdef INSTRET_CNT_EN
  ,
  output logic [INSTRET_W-1:0] instret
`endif
);

  state_e state_q, state_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Outputs are decoded from state/opcode; reset gates everything so that an
  // aborted instruction produces no further write pulses.
  always_comb begin
    state_d       = state_q;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = PCS_ALU;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_RS2;
    alu_op        = ALU_ADD;
    reg_write     = 1'b0;
    mem_to_reg    = M2R_ALUOUT;
    illegal_inst  = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRCB_FOUR;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = S_DECODE;
          end
        end
        S_DECODE: begin
          // branch/JAL target computed here into ALUOut
          alu_src_a = SRCA_OLDPC;
          alu_src_b = SRCB_IMM;
          state_d   = op_supported(opcode) ? S_EXEC : S_HALT;
        end
        S_EXEC: begin
          case (opcode)
            OP_R: begin
              alu_src_a = SRCA_RS1;
              alu_op    = ALU_RFN;
              state_d   = S_WB;
            end
            OP_I: begin
              alu_src_a = SRCA_RS1;
              alu_src_b = SRCB_IMM;
              alu_op    = ALU_IFN;
              state_d   = S_WB;
            end
            OP_LOAD, OP_STORE: begin
              alu_src_a = SRCA_RS1;
              alu_src_b = SRCB_IMM;
              state_d   = S_MEM;
            end
            OP_BRANCH: begin
              alu_src_a     = SRCA_RS1;
              alu_op        = ALU_SUB;
              pc_write_cond = 1'b1;
              pc_source     = PCS_ALUOUT;
              state_d       = S_FETCH;
            end
            OP_JAL: begin
              pc_write   = 1'b1;
              pc_source  = PCS_ALUOUT;
              reg_write  = 1'b1;
              mem_to_reg = M2R_PC;
              state_d    = S_FETCH;
            end
            OP_JALR: begin
              alu_src_a  = SRCA_RS1;
              alu_src_b  = SRCB_IMM;
              pc_write   = 1'b1;
              pc_source  = PCS_JALR;
              reg_write  = 1'b1;
              mem_to_reg = M2R_PC;
              state_d    = S_FETCH;
            end
            // opcode changed under us after DECODE: treat as illegal
            default: state_d = S_HALT;
          endcase
        end
        S_MEM: begin
          if (opcode == OP_LOAD) mem_read  = 1'b1;
          else                   mem_write = 1'b1;
          if (mem_ready) state_d = (opcode == OP_LOAD) ? S_WB : S_FETCH;
        end
        S_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = (opcode == OP_LOAD) ? M2R_MDR : M2R_ALUOUT;
          state_d    = S_FETCH;
        end
        S_HALT: illegal_inst = 1'b1;
        default: state_d = S_FETCH;
      endcase
    end
  end

`ifdef INSTRET_CNT_EN
  logic [INSTRET_W-1:0] instret_q;
  logic                 retire;

  // An instruction retires when the FSM returns to FETCH from a working state.
  assign retire = (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) &&
                  (state_d == S_FETCH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       instret_q <= '0;
    else if (retire) instret_q <= instret_q + {{(INSTRET_W-1){1'b0}}, 1'b1};
  end

  assign instret = instret_q;
`endif

endmodule
